// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory port.
//
// Handshake rules:
//   - A requester raises its req with address/control stable and holds all of
//     it until its one-cycle ready pulse. rdata is meaningful only while ready
//     is high.
//   - The arbiter raises m_req with stable m_addr/m_we/m_wdata and holds them
//     until the memory answers with a one-cycle m_ack. m_rdata is sampled in
//     the m_ack cycle.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  // Arbiter view: serves the two pipeline ports, drives the memory.
  modport master (
    input  i_req, i_addr,
    output i_rdata, i_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  // Environment view: pipeline requesters plus the memory itself.
  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch port and the load/store port. One transaction at a time:
// IDLE picks a winner, BUSY waits for m_ack (or times out), RESP pulses the
// owner's ready for one cycle.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic               clk,
  input  logic               resetn,
  mem_port_arbiter_if.master bus,
  output logic               err,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // Abort in the TIMEOUT-th BUSY cycle if that cycle also brings no ack.
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          owner_d;     // 1 = load/store port owns the transaction
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] wait_cnt;
  logic          err_q;

  logic grant_i;
  logic grant_d;
  logic timeout_hit;

  // Fetch wins a collision only once it has been passed over STARVE_LIMIT times.
  assign grant_i     = (state == S_IDLE) && bus.i_req &&
                       (!bus.d_req || (starve_cnt == STARVE_MAX));
  assign grant_d     = (state == S_IDLE) && bus.d_req && !grant_i;
  assign timeout_hit = (state == S_BUSY) && !bus.m_ack && (wait_cnt == WAIT_LAST);

  // Transaction sequencer: arbitration, memory wait, response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      owner_d    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_i) begin
            owner_d    <= 1'b0;
            addr_q     <= bus.i_addr;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            state      <= S_BUSY;
          end else if (grant_d) begin
            owner_d  <= 1'b1;
            addr_q   <= bus.d_addr;
            we_q     <= bus.d_we;
            wdata_q  <= bus.d_wdata;
            wait_cnt <= '0;
            state    <= S_BUSY;
            // Only a D-grant that actually passes over a waiting fetch counts.
            if (bus.i_req) begin
              if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        S_BUSY: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (bus.m_ack) begin
            // Stores latch the returned word as well; the pipeline ignores it.
            if (owner_d) d_rdata_q <= bus.m_rdata;
            else         i_rdata_q <= bus.m_rdata;
            state <= S_RESP;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (owner_d) d_rdata_q <= '0;
            else         i_rdata_q <= '0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.m_req   = (state == S_BUSY);
  assign bus.m_we    = (state == S_BUSY) && we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  assign bus.i_ready = (state == S_RESP) && !owner_d;
  assign bus.d_ready = (state == S_RESP) && owner_d;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester and memory processes, a negedge
// monitor, and a transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int TMO   = 255;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
  typedef logic [AW+DW:0] grant_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       err;
  logic [1:0] state_dbg;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- shared bench state ----------------
  cmd_t          i_cmd_q[$];
  cmd_t          d_cmd_q[$];
  cmd_t          mi_q[$];
  cmd_t          md_q[$];
  logic [DW:0]   done_q[$];
  logic [DW:0]   exp_q[$];
  grant_t        grant_q[$];
  grant_t        exp_grant_q[$];
  int            lat_q[$];
  int            ready_cyc_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];

  bit            mem_silent = 1'b0;
  bit            rand_lat   = 1'b0;
  int            mem_lat    = 0;
  bit            spur_ack   = 1'b0;

  int            s_model = 0;
  logic [DW-1:0] last_i  = '0;
  logic [DW-1:0] last_d  = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // ---------------- driver processes ----------------
  initial begin : i_requester
    cmd_t c;
    bit   busy;
    busy = 1'b0;
    bus.i_req  = 1'b0;
    bus.i_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        busy = 1'b0;
        bus.i_req = 1'b0;
      end else begin
        if (busy && bus.i_ready) busy = 1'b0;
        if (!busy) begin
          if (i_cmd_q.size() > 0) begin
            c = i_cmd_q.pop_front();
            bus.i_req  = 1'b1;
            bus.i_addr = c.addr;
            busy = 1'b1;
          end else begin
            bus.i_req  = 1'b0;
            bus.i_addr = $urandom;
          end
        end
      end
    end
  end

  initial begin : d_requester
    cmd_t c;
    bit   busy;
    busy = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        busy = 1'b0;
        bus.d_req = 1'b0;
      end else begin
        if (busy && bus.d_ready) busy = 1'b0;
        if (!busy) begin
          if (d_cmd_q.size() > 0) begin
            c = d_cmd_q.pop_front();
            bus.d_req   = 1'b1;
            bus.d_we    = c.we;
            bus.d_addr  = c.addr;
            bus.d_wdata = c.wdata;
            busy = 1'b1;
          end else begin
            bus.d_req   = 1'b0;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
          end
        end
      end
    end
  end

  // Memory: answers after a fixed or random number of wait cycles; a store
  // returns the word held before the write.
  initial begin : responder
    int cnt;
    int cur_lat;
    bit started;
    cnt = 0; cur_lat = 0; started = 1'b0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.m_ack = 1'b0;
      if (!resetn || !bus.m_req) begin
        cnt = 0;
        started = 1'b0;
        if (resetn && spur_ack) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = $urandom;
        end
      end else if (!mem_silent) begin
        if (!started) begin
          cur_lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
          started = 1'b1;
        end
        if (cnt >= cur_lat) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = mem_rd(bus.m_addr);
          if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
          lat_q.push_back(cur_lat);
          cnt = 0;
          started = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    int            busy_len;
    int            e_len;
    logic          prev_req;
    grant_t        prev_g;
    grant_t        cur_g;
    busy_len = 0; prev_req = 1'b0; prev_g = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy_len = 0;
        prev_req = 1'b0;
      end else begin
        cur_g = {bus.m_we, bus.m_addr, bus.m_wdata};
        if (bus.m_req && !prev_req) begin
          grant_q.push_back(cur_g);
          busy_len = 0;
        end
        if (bus.m_req && prev_req) chk("m_stable", cur_g, prev_g);
        if (bus.m_req) busy_len++;
        if (bus.i_ready || bus.d_ready) begin
          chk("one_ready", {bus.i_ready, bus.d_ready} == 2'b11, 1'b0);
          chk("ready_after_busy", {prev_req, bus.m_req}, 2'b10);
          if (lat_q.size() > 0) e_len = lat_q.pop_front() + 1;
          else                  e_len = TMO;
          chk("busy_len", busy_len, e_len);
          done_q.push_back({bus.d_ready, bus.d_ready ? bus.d_rdata : bus.i_rdata});
          ready_cyc_q.push_back(cyc);
        end
        prev_req = bus.m_req;
        prev_g   = cur_g;
      end
    end
  end

  // ---------------- reference model ----------------
  // Serves the pending commands one at a time: load/store first, except that
  // fetch wins once it has been passed over LIMIT times in a row.
  task automatic model_phase(input bit silent);
    while (mi_q.size() > 0 || md_q.size() > 0) begin
      cmd_t          c;
      bit            is_d;
      logic [DW-1:0] rd;
      if (md_q.size() > 0 && (mi_q.size() == 0 || s_model < LIMIT)) begin
        is_d = 1'b1;
        c = md_q.pop_front();
        s_model = (mi_q.size() > 0) ? ((s_model < LIMIT) ? s_model + 1 : LIMIT) : 0;
      end else begin
        is_d = 1'b0;
        c = mi_q.pop_front();
        c.we = 1'b0;
        c.wdata = '0;
        s_model = 0;
      end
      rd = silent ? '0 : ref_rd(c.addr);
      if (!silent && c.we) ref_mem[c.addr] = c.wdata;
      exp_grant_q.push_back({c.we, c.addr, c.wdata});
      exp_q.push_back({is_d, rd});
      if (is_d) last_d = rd;
      else      last_i = rd;
    end
  endtask

  task automatic launch(input bit silent);
    @(negedge clk);
    ready_cyc_q.delete();
    i_cmd_q = mi_q;
    d_cmd_q = md_q;
    model_phase(silent);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, done_q.size(), n);
  endtask

  task automatic check_phase(input string tag, output logic [15:0] seq);
    seq = '0;
    while (exp_q.size() > 0) begin
      logic [DW:0] e;
      logic [DW:0] a;
      grant_t      eg;
      grant_t      ag;
      e  = exp_q.pop_front();
      a  = (done_q.size() > 0) ? done_q.pop_front() : 'x;
      eg = exp_grant_q.pop_front();
      ag = (grant_q.size() > 0) ? grant_q.pop_front() : 'x;
      chk({tag, "_grant"}, ag, eg);
      chk({tag, "_done"}, a, e);
      seq = {seq[14:0], a[DW]};
    end
    chk({tag, "_extra"}, done_q.size() + grant_q.size(), 0);
    chk({tag, "_i_hold"}, bus.i_rdata, last_i);
    chk({tag, "_d_hold"}, bus.d_rdata, last_d);
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = w;
    return c;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin : main
    logic [15:0] seq;

    repeat (3) @(negedge clk);
    chk("rst_m_req",   bus.m_req,   1'b0);
    chk("rst_m_we",    bus.m_we,    1'b0);
    chk("rst_m_addr",  bus.m_addr,  '0);
    chk("rst_i_ready", bus.i_ready, 1'b0);
    chk("rst_d_ready", bus.d_ready, 1'b0);
    chk("rst_rdata",   {bus.i_rdata, bus.d_rdata}, '0);
    chk("rst_err",     err,         1'b0);
    @(posedge clk); #3 resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single load with three memory wait cycles.
    mem[32'h100] = 32'h1234_5678;
    ref_mem[32'h100] = 32'h1234_5678;
    mem_lat = 3;
    md_q.push_back(mk(1'b0, 32'h100, 32'h0));
    launch(1'b0);
    wait_done(1, 40, "load");
    chk("load_rdata", bus.d_rdata, 32'h1234_5678);
    check_phase("load", seq);
    chk("load_port", seq[0], 1'b1);

    // Simultaneous store and fetch, zero-wait memory.
    mem_lat = 0;
    md_q.push_back(mk(1'b1, 32'h40, 32'hCAFE));
    mi_q.push_back(mk(1'b0, 32'h200, 32'h0));
    launch(1'b0);
    wait_done(2, 40, "both");
    chk("both_rdy_n", ready_cyc_q.size(), 2);
    if (ready_cyc_q.size() == 2) chk("both_i_after_d", ready_cyc_q[1] - ready_cyc_q[0], 3);
    check_phase("both", seq);
    chk("both_order", seq[1:0], 2'b10);

    // Continuous loads/stores against a waiting fetch: starvation relief.
    for (int k = 0; k < 10; k++) md_q.push_back(mk(1'($urandom_range(0, 1)), rand_addr(), $urandom));
    md_q[3].addr = 32'h40;
    md_q[3].we   = 1'b0;
    mi_q.push_back(mk(1'b0, 32'h40, 32'h0));
    mi_q.push_back(mk(1'b0, rand_addr(), 32'h0));
    launch(1'b0);
    wait_done(12, 200, "starve");
    check_phase("starve", seq);
    chk("starve_pattern", seq[11:0], 12'b1111_0111_1011);

    // Random traffic mixes with random memory latency.
    rand_lat = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int ni;
      int nd;
      ni = $urandom_range(1, 4);
      nd = $urandom_range(0, 7);
      for (int k = 0; k < ni; k++) mi_q.push_back(mk(1'b0, rand_addr(), 32'h0));
      for (int k = 0; k < nd; k++) md_q.push_back(mk(1'($urandom_range(0, 1)), rand_addr(), $urandom));
      launch(1'b0);
      wait_done(ni + nd, 40 * (ni + nd), "rand");
      check_phase("rand", seq);
    end
    rand_lat = 1'b0;

    // Memory never answers: timeout, sticky error.
    mem_silent = 1'b1;
    md_q.push_back(mk(1'b0, 32'h80, 32'h0));
    launch(1'b1);
    wait_done(1, 300, "tmo");
    chk("tmo_err", err, 1'b1);
    chk("tmo_m_req", bus.m_req, 1'b0);
    check_phase("tmo", seq);
    mem_silent = 1'b0;
    mi_q.push_back(mk(1'b0, 32'h100, 32'h0));
    launch(1'b0);
    wait_done(1, 40, "post_tmo");
    check_phase("post_tmo", seq);
    chk("err_sticky", err, 1'b1);

    // Spurious ack while idle must not complete anything.
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_done", done_q.size(), 0);
    chk("spur_i_rdata", bus.i_rdata, last_i);
    chk("spur_d_rdata", bus.d_rdata, last_d);

    // Asynchronous reset in the middle of a transaction.
    mem_silent = 1'b1;
    @(negedge clk);
    d_cmd_q.push_back(mk(1'b0, 32'h300, 32'h0));
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", bus.m_req, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_m_req", bus.m_req, 1'b0);
    chk("arst_ready", {bus.i_ready, bus.d_ready}, 2'b00);
    chk("arst_err",   err, 1'b0);
    chk("arst_rdata", {bus.i_rdata, bus.d_rdata}, '0);
    s_model = 0;
    last_i  = '0;
    last_d  = '0;
    grant_q.delete();
    done_q.delete();
    lat_q.delete();
    exp_q.delete();
    exp_grant_q.delete();
    mem_silent = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #3 resetn = 1'b1;
    repeat (2) @(negedge clk);
    md_q.push_back(mk(1'b0, 32'h40, 32'h0));
    mi_q.push_back(mk(1'b0, 32'h100, 32'h0));
    launch(1'b0);
    wait_done(2, 60, "post_rst");
    check_phase("post_rst", seq);
    chk("post_rst_order", seq[1:0], 2'b10);
    chk("post_rst_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
